// File: rtl/gpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpu_pkg
// Description : Shared encodings for the scheduler, fetcher and LSU.
// Revision    : 1.0 - initial release
// ============================================================================
package gpu_pkg;

  // Scheduler stage encodings driven on core_state.
  localparam logic [2:0] CORE_IDLE    = 3'b000;
  localparam logic [2:0] CORE_FETCH   = 3'b001;
  localparam logic [2:0] CORE_DECODE  = 3'b010;
  localparam logic [2:0] CORE_REQUEST = 3'b011;
  localparam logic [2:0] CORE_WAIT    = 3'b100;
  localparam logic [2:0] CORE_EXECUTE = 3'b101;
  localparam logic [2:0] CORE_UPDATE  = 3'b110;
  localparam logic [2:0] CORE_DONE    = 3'b111;

  // Instruction fetcher progress encodings.
  localparam logic [2:0] FETCHER_IDLE     = 3'b000;
  localparam logic [2:0] FETCHER_FETCHING = 3'b001;
  localparam logic [2:0] FETCHER_FETCHED  = 3'b010;

  // LSU progress as seen by the scheduler.
  typedef enum logic [1:0] {
    LSU_IDLE       = 2'b00,
    LSU_REQUESTING = 2'b01,
    LSU_WAITING    = 2'b10,
    LSU_DONE       = 2'b11
  } lsu_state_t;

  // Counter width able to hold LIMIT; at least one bit.
  function automatic int unsigned wd_width(input int unsigned limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : lsu_watchdog
// Description : Saturating WAITING-cycle counter. expired pulses on the
//               LIMIT-th counted cycle; LIMIT=0 never expires.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_watchdog
  import gpu_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int unsigned    W    = wd_width(LIMIT);
  localparam logic [W-1:0]   LAST = W'((LIMIT == 0) ? 0 : LIMIT - 1);
  localparam logic [W-1:0]   MAX  = {W{1'b1}};

  logic [W-1:0] cnt_q, cnt_d;

  // Expiry is flagged while the final allowed cycle is being counted, so the
  // owner leaves WAITING after exactly LIMIT cycles.
  assign expired = (LIMIT != 0) && count && (cnt_q == LAST);

  // Next count: clear wins, otherwise count up and stick at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count && (cnt_q != MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module      : lsu
// Description : Per-thread load/store unit. Issues one data-memory read or
//               write per memory instruction and reports progress to the
//               scheduler on lsu_state.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu
  import gpu_pkg::*;
#(
  parameter int unsigned ADDR_BITS      = 8,
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [2:0]           core_state,
  input  logic                 decoded_mem_read_enable,
  input  logic                 decoded_mem_write_enable,
  input  logic [DATA_BITS-1:0] rs,
  input  logic [DATA_BITS-1:0] rt,
  output logic                 mem_read_valid,
  output logic [ADDR_BITS-1:0] mem_read_address,
  input  logic                 mem_read_ready,
  input  logic [DATA_BITS-1:0] mem_read_data,
  output logic                 mem_write_valid,
  output logic [ADDR_BITS-1:0] mem_write_address,
  output logic [DATA_BITS-1:0] mem_write_data,
  input  logic                 mem_write_ready,
  output logic [1:0]           lsu_state,
  output logic [DATA_BITS-1:0] lsu_out,
  output logic                 lsu_error
);

  lsu_state_t           state_q, state_d;
  logic                 rd_op_q, rd_op_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;
  logic                 rvalid_q, rvalid_d;
  logic                 wvalid_q, wvalid_d;
  logic [ADDR_BITS-1:0] raddr_q, raddr_d;
  logic [ADDR_BITS-1:0] waddr_q, waddr_d;
  logic [DATA_BITS-1:0] wdout_q, wdout_d;
  logic [DATA_BITS-1:0] out_q, out_d;
  logic                 err_q, err_d;

  logic [ADDR_BITS-1:0] rs_addr;
  logic                 ready_match;
  logic                 wd_expired;

  generate
    if (ADDR_BITS > DATA_BITS) begin : g_addr_zext
      assign rs_addr = {{(ADDR_BITS - DATA_BITS){1'b0}}, rs};
    end else begin : g_addr_trunc
      assign rs_addr = rs[ADDR_BITS-1:0];
    end
  endgenerate

  // Only the channel of the latched operation can complete the transaction.
  assign ready_match = rd_op_q ? mem_read_ready : mem_write_ready;

  lsu_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state_q == LSU_REQUESTING),
    .count   ((state_q == LSU_WAITING) && !ready_match),
    .expired (wd_expired)
  );

  // Next-state and request-register logic for the transaction FSM.
  always_comb begin
    state_d  = state_q;
    rd_op_d  = rd_op_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rvalid_d = rvalid_q;
    wvalid_d = wvalid_q;
    raddr_d  = raddr_q;
    waddr_d  = waddr_q;
    wdout_d  = wdout_q;
    out_d    = out_q;
    err_d    = err_q;
    case (state_q)
      LSU_IDLE: begin
        // enable only gates starting; an in-flight transaction always finishes.
        if (enable && (core_state == CORE_REQUEST) &&
            (decoded_mem_read_enable || decoded_mem_write_enable)) begin
          state_d = LSU_REQUESTING;
          rd_op_d = decoded_mem_read_enable;  // read wins when both are set
          addr_d  = rs_addr;
          wdata_d = rt;
        end
      end
      LSU_REQUESTING: begin
        state_d = LSU_WAITING;
        if (rd_op_q) begin
          rvalid_d = 1'b1;
          raddr_d  = addr_q;
        end else begin
          wvalid_d = 1'b1;
          waddr_d  = addr_q;
          wdout_d  = wdata_q;
        end
      end
      LSU_WAITING: begin
        // A handshake on the final watchdog cycle takes priority over timeout.
        if (ready_match) begin
          rvalid_d = 1'b0;
          wvalid_d = 1'b0;
          state_d  = LSU_DONE;
          if (rd_op_q) out_d = mem_read_data;
        end else if (wd_expired) begin
          rvalid_d = 1'b0;
          wvalid_d = 1'b0;
          err_d    = 1'b1;
          state_d  = LSU_DONE;
        end
      end
      LSU_DONE: begin
        if (core_state == CORE_UPDATE) state_d = LSU_IDLE;
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  // State and request registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= LSU_IDLE;
      rd_op_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rvalid_q <= 1'b0;
      wvalid_q <= 1'b0;
      raddr_q  <= '0;
      waddr_q  <= '0;
      wdout_q  <= '0;
      out_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_op_q  <= rd_op_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rvalid_q <= rvalid_d;
      wvalid_q <= wvalid_d;
      raddr_q  <= raddr_d;
      waddr_q  <= waddr_d;
      wdout_q  <= wdout_d;
      out_q    <= out_d;
      err_q    <= err_d;
    end
  end

  assign mem_read_valid    = rvalid_q;
  assign mem_read_address  = raddr_q;
  assign mem_write_valid   = wvalid_q;
  assign mem_write_address = waddr_q;
  assign mem_write_data    = wdout_q;
  assign lsu_state         = state_q;
  assign lsu_out           = out_q;
  assign lsu_error         = err_q;

endmodule
`default_nettype wire
